// File: rtl/hexn_pkg.sv
// Shared types and helpers for the 74HC595 scan display driver:
// serialiser FSM states, hex-to-segment encoding and frame-word width.
package hexn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_L,
    SHIFT_H,
    LATCH
  } tx_state_e;

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Frame word is {Seg[7:0], Sel[digits-1:0]}.
  function automatic int fw_width(input int digits);
    return 8 + digits;
  endfunction

endpackage

// File: rtl/hexn_595_scan_sr595_tx.sv
// Start/busy/done serialiser for a 74HC595 chain: shifts WIDTH bits MSB first
// on DS/SHCP, then pulses STCP for SHCP_DIV cycles to latch them.
module sr595_tx
  import hexn_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SHCP_DIV = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] word_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             ds_o,
  output logic             shcp_o,
  output logic             stcp_o
);

  localparam int PW = (SHCP_DIV > 1) ? $clog2(SHCP_DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  tx_state_e        state_q, state_d;
  logic [PW-1:0]    ph_q, ph_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             ph_last, bit_last;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      done_q  <= done_d;
    end
  end

  // Shift data needs no reset: DS is gated to 0 whenever the FSM is idle.
  always_ff @(posedge Clk) begin
    sh_q <= sh_d;
  end

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    done_d   = 1'b0;
    ph_last  = (ph_q == PW'(SHCP_DIV - 1));
    bit_last = (bit_q == BW'(WIDTH - 1));
    case (state_q)
      IDLE: begin
        if (start_i) begin
          sh_d    = word_i;
          ph_d    = '0;
          bit_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        ph_d    = '0;
        state_d = SHIFT_L;
      end
      SHIFT_L: begin
        if (ph_last) begin
          ph_d    = '0;
          state_d = SHIFT_H;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      SHIFT_H: begin
        if (ph_last) begin
          ph_d = '0;
          if (bit_last) begin
            state_d = LATCH;
          end else begin
            // Next bit appears on DS together with the SHCP falling edge.
            bit_d   = bit_q + 1'b1;
            sh_d    = {sh_q[WIDTH-2:0], 1'b0};
            state_d = SHIFT_L;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      LATCH: begin
        if (ph_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign shcp_o = (state_q == SHIFT_H);
  assign stcp_o = (state_q == LATCH);
  assign ds_o   = (state_q != IDLE) & sh_q[WIDTH-1];

endmodule

// File: rtl/hexn_595_scan.sv
// N-digit hex 7-segment scan driver: per-frame input snapshot, leading-zero
// suppression, blanking and polarity, serialised to a 74HC595 chain.
module hexn_595_scan
  import hexn_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int SHCP_DIV       = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                En,
  input  logic [4*DIGITS-1:0] Disp_data,
  input  logic [DIGITS-1:0]   Dp,
  input  logic [DIGITS-1:0]   Blank,
  input  logic                Lz_en,
  output logic                DS,
  output logic                SHCP,
  output logic                STCP,
  output logic                Frame_done
);

  localparam int FW      = fw_width(DIGITS);
  localparam int XFER    = 1 + 2 * SHCP_DIV * FW + SHCP_DIV;
  localparam int CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (DIGITS < 1 || DIGITS > 16) begin : g_bad_digits
    $error("hexn_595_scan: DIGITS must be 1..16");
  end
  if (SHCP_DIV < 1) begin : g_bad_shcp_div
    $error("hexn_595_scan: SHCP_DIV must be >= 1");
  end
  if (SCAN_DIV <= XFER) begin : g_bad_scan_div
    $error("hexn_595_scan: SCAN_DIV must exceed one transfer length");
  end

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       dig_q, dig_d;
  logic                last_q, last_d;
  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]   dp_q, blank_q;
  logic                lz_q;

  logic                tick, tx_busy, tx_done;
  logic                live;
  logic [4*DIGITS-1:0] src_data;
  logic [DIGITS-1:0]   src_dp, src_blank, sel_oh;
  logic                src_lz, suppress;
  logic [3:0]          nib;
  logic [7:0]          seg_act, seg_out;
  logic [DIGITS-1:0]   sel_out;
  logic [FW-1:0]       word;

  // A slot tick waits for an idle serialiser, so a quick En off/on cannot clip a transfer.
  assign tick = En && (cnt_q == '0) && !tx_busy;

  always_comb begin
    cnt_d  = cnt_q;
    dig_d  = dig_q;
    last_d = last_q;
    if (!En) begin
      cnt_d = '0;
      dig_d = '0;
    end else if (cnt_q == '0 && tx_busy) begin
      cnt_d = '0;
    end else begin
      cnt_d = (cnt_q == CW'(SCAN_DIV - 1)) ? '0 : cnt_q + 1'b1;
    end
    if (tick) begin
      dig_d  = (dig_q == DW'(DIGITS - 1)) ? '0 : dig_q + 1'b1;
      last_d = (dig_q == DW'(DIGITS - 1));
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q  <= '0;
      dig_q  <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dig_q  <= dig_d;
      last_q <= last_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (tick && dig_q == '0) begin
      data_q  <= Disp_data;
      dp_q    <= Dp;
      blank_q <= Blank;
      lz_q    <= Lz_en;
    end
  end

  // Digit 0 is encoded from the live inputs in the same cycle they are snapshotted.
  always_comb begin
    live      = (dig_q == '0);
    src_data  = live ? Disp_data : data_q;
    src_dp    = live ? Dp : dp_q;
    src_blank = live ? Blank : blank_q;
    src_lz    = live ? Lz_en : lz_q;
    nib       = src_data[{dig_q, 2'b00} +: 4];
    suppress  = src_lz && (dig_q != '0) && ((src_data >> {dig_q, 2'b00}) == '0);
    seg_act   = (src_blank[dig_q] || suppress) ? 8'h00 : {src_dp[dig_q], hex2seg(nib)};
    seg_out   = (SEG_ACTIVE_LOW != 0) ? ~seg_act : seg_act;
    sel_oh    = '0;
    sel_oh[dig_q] = 1'b1;
    sel_out   = (SEL_ACTIVE_LOW != 0) ? ~sel_oh : sel_oh;
    word      = {seg_out, sel_out};
  end

  sr595_tx #(
    .WIDTH   (FW),
    .SHCP_DIV(SHCP_DIV)
  ) u_tx (
    .Clk    (Clk),
    .Reset  (Reset),
    .start_i(tick),
    .word_i (word),
    .busy_o (tx_busy),
    .done_o (tx_done),
    .ds_o   (DS),
    .shcp_o (SHCP),
    .stcp_o (STCP)
  );

  assign Frame_done = tx_done & last_q;

endmodule

// File: tb/tb_hexn_595_scan.sv
// Scoreboard bench for hexn_595_scan (8 digits, SCAN_DIV=100, SHCP_DIV=2, active-low).
module tb_hexn_595_scan;

  logic        Clk;
  logic        Reset;
  logic        En;
  logic [31:0] Disp_data;
  logic [7:0]  Dp;
  logic [7:0]  Blank;
  logic        Lz_en;
  logic        DS, SHCP, STCP, Frame_done;

  hexn_595_scan #(
    .DIGITS        (8),
    .SCAN_DIV      (100),
    .SHCP_DIV      (2),
    .SEG_ACTIVE_LOW(1),
    .SEL_ACTIVE_LOW(1)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .En        (En),
    .Disp_data (Disp_data),
    .Dp        (Dp),
    .Blank     (Blank),
    .Lz_en     (Lz_en),
    .DS        (DS),
    .SHCP      (SHCP),
    .STCP      (STCP),
    .Frame_done(Frame_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int rel0     = 0;
  int stcp_cnt = 0;
  logic [15:0] exp_q[$];

  // Hand-encoded active-low segment bytes, digit 7 in the top byte down to digit 0.
  localparam logic [63:0] SEG_OLD   = 64'hF9A4B0999282F880; // 32'h12345678
  localparam logic [63:0] SEG_NEW   = 64'h908883C6A1868EC0; // 32'h9ABCDEF0
  localparam logic [63:0] SEG_LZ    = 64'hFFFFFFFFFFFF88C0; // 32'h000000A0, Lz on
  localparam logic [63:0] SEG_BLANK = 64'hC0C0C0C0C0C088FF; // A0, Dp0 + Blank0
  localparam logic [63:0] SEG_DP    = 64'hC0C0C0C0C0C08840; // A0, Dp0 lit

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [63:0] segs);
    logic [7:0] sel;
    for (int d = 0; d < 8; d++) begin
      sel = 8'h01 << d;
      exp_q.push_back({segs[8*d +: 8], ~sel});
    end
  endtask

  task automatic wait_until(input int p);
    while (cyc - rel0 < p) @(negedge Clk);
  endtask

  // Monitor: rebuild each word from DS at SHCP rises, compare at STCP rise.
  logic [15:0] cap = '0;
  int   nbits = 0;
  int   last_rise = 0;
  logic shcp_prev = 1'b0, stcp_prev = 1'b0, ds_prev = 1'b0;
  logic [15:0] want;

  always @(negedge Clk) begin
    if (Reset) begin
      nbits     = 0;
      shcp_prev = 1'b0;
      stcp_prev = 1'b0;
    end else begin
      if (SHCP && shcp_prev) check("ds_stable_while_shcp_high", 32'(DS), 32'(ds_prev));
      if (SHCP && !shcp_prev) begin
        cap       = {cap[14:0], DS};
        nbits     = nbits + 1;
        last_rise = cyc;
      end
      if (STCP && !stcp_prev) begin
        stcp_cnt++;
        check("shcp_rises_per_word", 32'(nbits), 32'd16);
        check("stcp_delay_after_last_rise", 32'(cyc - last_rise), 32'd2);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_transfer: got word %h, expected no transfer (t=%0t)", cap, $time);
        end else begin
          want = exp_q.pop_front();
          check("frame_word", 32'(cap), 32'(want));
        end
        nbits = 0;
      end
      shcp_prev = SHCP;
      stcp_prev = STCP;
      ds_prev   = DS;
    end
  end

  initial begin
    repeat (20000) @(posedge Clk);
    $display("FAIL watchdog: got no end of test, expected finish within 20000 cycles");
    $fatal(1, "watchdog");
  end

  int t_fd0, t_fd1, saved;
  bit found;

  initial begin
    Reset = 1'b1; En = 1'b0; Disp_data = '0; Dp = '0; Blank = '0; Lz_en = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_ds", 32'(DS), 32'd0);
    check("reset_shcp", 32'(SHCP), 32'd0);
    check("reset_stcp", 32'(STCP), 32'd0);
    check("reset_frame_done", 32'(Frame_done), 32'd0);

    // Start a transfer, then hit reset while SHCP is high mid-shift.
    Disp_data = 32'h12345678;
    Reset = 1'b0; En = 1'b1; rel0 = cyc;
    wait_until(4);
    check("pre_reset_shcp", 32'(SHCP), 32'd1);
    check("pre_reset_ds", 32'(DS), 32'd1);
    Reset = 1'b1;
    #1;
    check("async_reset_ds", 32'(DS), 32'd0);
    check("async_reset_shcp", 32'(SHCP), 32'd0);
    check("async_reset_stcp", 32'(STCP), 32'd0);
    check("async_reset_frame_done", 32'(Frame_done), 32'd0);
    repeat (3) @(negedge Clk);

    push_frame(SEG_OLD);
    Reset = 1'b0; rel0 = cyc;

    wait_until(350);                 // mid digit 3 of frame 0
    Disp_data = 32'h9ABCDEF0;
    push_frame(SEG_NEW);

    wait_until(950);                 // frame 1
    Disp_data = 32'h000000A0; Lz_en = 1'b1;
    push_frame(SEG_LZ);

    wait_until(1750);                // frame 2
    Lz_en = 1'b0; Dp = 8'h01; Blank = 8'h01;
    push_frame(SEG_BLANK);

    wait_until(2550);                // frame 3
    Blank = 8'h00;
    push_frame(SEG_DP);

    found = 0; t_fd0 = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge Clk);
      if (Frame_done) begin found = 1; t_fd0 = cyc - rel0; end
    end
    check("frame_done_seen", 32'(found), 32'd1);
    check("frame_done_time", 32'(t_fd0), 32'd3168);
    @(negedge Clk);
    check("frame_done_width", 32'(Frame_done), 32'd0);
    found = 0; t_fd1 = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge Clk);
      if (Frame_done) begin found = 1; t_fd1 = cyc - rel0; end
    end
    check("frame_done_seen_again", 32'(found), 32'd1);
    check("frame_done_period", 32'(t_fd1 - t_fd0), 32'd800);

    // Drop En during frame 5 digit 0: that word still latches, nothing follows.
    exp_q.push_back(16'h40FE);
    wait_until(4020);
    En = 1'b0;
    wait_until(4100);
    check("en_drop_word_latched", 32'(exp_q.size()), 32'd0);
    saved = stcp_cnt;
    wait_until(4500);
    check("no_stcp_while_disabled", 32'(stcp_cnt), 32'(saved));

    // Re-enable: scan resumes at digit 0.
    exp_q.push_back(16'h40FE);
    En = 1'b1;
    wait_until(4650);
    En = 1'b0;
    check("restart_at_digit0", 32'(exp_q.size()), 32'd0);
    check("restart_one_transfer", 32'(stcp_cnt), 32'(saved + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
